y86_mem_arbiter: RTL
====================

Name: y86_mem_arbiter

Overview:
Two-master arbiter and sequencer for the single y86 memory bus (address, write data, read data, read/write strobes). Master 0 is the CPU fetch/load/store port. Master 1 is the loader/debug port. The block grants the bus round-robin, drives one access at a time onto the memory, waits a fixed read latency, and returns data with a one-cycle acknowledge pulse. It sits between the processor core plus loader and the memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 1, cycles from the issue cycle to valid mem_rdata (legal range 1..7)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
m0_req  input  1  master 0 request, held until m0_ack
m0_we  input  1  master 0 write (1) / read (0)
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_ack  output  1  master 0 transfer-complete pulse
m0_rdata  output  DATA_W  read data, valid while m0_ack=1
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0, for master 1
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_we  output  1  memory write strobe
mem_re  output  1  memory read strobe
mem_rdata  input  DATA_W  memory read data
busy  output  1  transaction in progress (state != IDLE)
owner  output  1  current grant holder (0/1), meaningful only while busy

Behaviour:
- Reset values (rst is synchronous active-high, clock clk):
  - state = IDLE
  - all acks, mem_we, mem_re, busy = 0
  - mem_addr, mem_wdata, rdata register = 0
  - last_served = 1, so master 0 wins the first tie
  - owner = 0
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant !last_served.
  - On grant: latch owner and that master's we/addr/wdata into internal registers, then go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata come from the latched request.
  - mem_we = latched we; mem_re = !latched we.
  - Write: go to DONE.
  - Read: load counter with MEM_LAT-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter == 0: capture mem_rdata into the rdata register and go to DONE.
  - The memory guarantees mem_rdata is valid in the MEM_LAT-th cycle after ISSUE.
- DONE (1 cycle):
  - ack[owner] = 1.
  - last_served <= owner.
  - Go to IDLE.
- Outside ISSUE: mem_we = mem_re = 0 and mem_addr = mem_wdata = 0. The bus is never left floating or stale.
- Latency, counting the IDLE cycle in which req is seen as cycle 0:
  - Write: mem_we in cycle 1, ack in cycle 2.
  - Read: mem_re in cycle 1, ack in cycle 2+MEM_LAT.
- Handshake:
  - A master keeps req and all request fields stable until it sees ack high.
  - At the edge ending the ack cycle, the master either drops req or presents its next request.
  - The mandatory IDLE cycle after DONE means there are no back-to-back grants; the minimum spacing is 1 idle cycle.
- m0_rdata and m1_rdata are both driven from the shared rdata register.
  - The value holds until the next read capture.
  - It is defined only while the port's ack is high.
  - A write does not modify rdata.
- Request fields are sampled only in IDLE at grant. Changes during ISSUE/WAIT/DONE are ignored.
- A request arriving mid-transaction waits. Round-robin guarantees each master is served within one other transaction.
- Reset mid-operation (any state): the next state is IDLE with all reset values. No ack is issued for the aborted transfer, and mem_we/mem_re drop at that edge.
- An ack is never asserted for a master that is not the owner. At most one ack is high per cycle.

Test Plan:
- MEM_LAT=2. m0 read of addr 0x10, memory returns 0xDEADBEEF 2 cycles after issue -> mem_re=1 in cycle 1 only with mem_addr=0x10; m0_ack=1 in cycle 4 with m0_rdata=0xDEADBEEF; m1_ack stays 0.
- m1 write addr 0x20, data 0x12345678 -> mem_we=1 in cycle 1 with mem_addr=0x20 and mem_wdata=0x12345678; m1_ack in cycle 2; rdata unchanged.
- Both masters request reads at once, right after reset -> m0 served first, then m1 after one IDLE cycle. Both request again -> m0 wins, since last_served=1.
- m0 holds req continuously while m1 requests once -> grant order m0, m1, m0. No master is served twice in a row while the other waits.
- MEM_LAT=3 read, rst asserted in the second WAIT cycle -> next cycle busy=0, no ack, mem_re=0, rdata=0. A fresh m1 read afterwards completes normally with ack at cycle 5.
- No requests for 10 cycles -> busy=0, mem_we=mem_re=0, mem_addr=0 throughout.

Source files
------------

// File: rtl/y86_mem_arbiter.sv
// Round-robin arbiter between the CPU port (m0) and the loader/debug port (m1)
// for the single y86 memory bus; one access at a time with fixed read latency.
module y86_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              w_grant;
  logic              w_gowner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  logic              r_owner;
  logic              r_we;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [2:0]        r_cnt;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_mem_we;
  logic              r_mem_re;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  // Next-state and grant decision; on a tie the master not served last wins.
  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_gowner = r_owner;
    case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_grant  = 1'b1;
          w_gowner = ~r_last;
        end else if (m0_req) begin
          w_grant  = 1'b1;
          w_gowner = 1'b0;
        end else if (m1_req) begin
          w_grant  = 1'b1;
          w_gowner = 1'b1;
        end else begin
          w_grant  = 1'b0;
        end
        if (w_grant) begin
          w_next = S_ISSUE;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_next = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields of whichever master is being granted this cycle.
  always_comb begin
    if (w_gowner) begin
      w_sel_we    = m1_we;
      w_sel_addr  = m1_addr;
      w_sel_wdata = m1_wdata;
    end else begin
      w_sel_we    = m0_we;
      w_sel_addr  = m0_addr;
      w_sel_wdata = m0_wdata;
    end
  end

  // State register plus latched request, latency counter and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner <= w_gowner;
        r_we    <= w_sel_we;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if (r_state == S_WAIT && r_cnt == 3'd0) begin
        r_rdata <= mem_rdata;
      end
      if (r_state == S_DONE) begin
        r_last <= r_owner;
      end
    end
  end

  // Bus strobes, acks and busy are registered from the upcoming state so
  // the bus is driven only during ISSUE and is zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_we    <= w_grant & w_sel_we;
      r_mem_re    <= w_grant & ~w_sel_we;
      r_mem_addr  <= w_grant ? w_sel_addr : '0;
      r_mem_wdata <= w_grant ? w_sel_wdata : '0;
      r_ack0      <= (w_next == S_DONE) && !r_owner;
      r_ack1      <= (w_next == S_DONE) && r_owner;
      r_busy      <= (w_next != S_IDLE);
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign m0_ack    = r_ack0;
  assign m1_ack    = r_ack1;
  assign m0_rdata  = r_rdata;
  assign m1_rdata  = r_rdata;
  assign busy      = r_busy;
  assign owner     = r_owner;

endmodule
